// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: FSM encoding and SPI mode constants.
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LEAD  = ST_LEAD,
        SHIFT = ST_SHIFT,
        TRAIL = ST_TRAIL
    } spi_state_e;

    // Only mode 0 is implemented today; these are kept for later mode support.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Bus-side handshake between the register block (master) and the shift engine (slave).
interface spi_shift_engine_if #(
    parameter int WIDTH = 8
);

    logic             tx_start;
    logic [WIDTH-1:0] tx_byte;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;

    modport master (
        output tx_start,
        output tx_byte,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_start,
        input  tx_byte,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

endinterface

// File: rtl/spi_shift_engine_tick_gen.sv
// Clock divider: one-cycle half_tick every CLK_DIV cycles, restarted by clear.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic half_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Free-running modulo-CLK_DIV counter, held at zero while clear is high.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign half_tick = (div_cnt == LAST);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode-0 serializer: parallel word in, SCLK/MOSI/CS_N out, MISO word back, MSB first.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    spi_shift_engine_if.slave      bus,
    output logic                   sclk,
    output logic                   mosi,
    output logic                   cs_n,
    input  logic                   miso
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    spi_state_e       state_q,    state_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic             sclk_q,     sclk_d;
    logic             cs_n_q,     cs_n_d;
    logic             ready_q,    ready_d;
    logic [WIDTH-1:0] rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             half_tick;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == IDLE),
        .half_tick (half_tick)
    );

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        ready_d    = ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    tx_shift_d = bus.tx_byte;
                    cs_n_d     = 1'b0;
                    ready_d    = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = LEAD;
                end
            end
            LEAD: begin
                if (half_tick) begin
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], miso};
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (half_tick) begin
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = TRAIL;
                        end else begin
                            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[WIDTH-2:0], miso};
                    end
                end
            end
            TRAIL: begin
                if (half_tick) begin
                    cs_n_d     = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    ready_d    = 1'b1;
                    tx_shift_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transfer and returns all outputs to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= SPI_CPOL;
            cs_n_q     <= 1'b1;
            ready_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            ready_q    <= ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // MOSI is the top of the tx shift register, which is zero whenever the engine is idle.
    assign mosi         = tx_shift_q[WIDTH-1];
    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign bus.tx_ready = ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: loopback, slave model, back-to-back, reset abort, CLK_DIV=4.
module tb_spi_shift_engine;

    logic clk = 1'b0;
    logic reset;
    logic sclk, mosi, cs_n, miso;
    logic sclk4, mosi4, cs_n4;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   e0_cyc = 0;
    int   rise_count = 0;
    int   fall_count = 0;
    int   valid_count = 0;
    logic [7:0] mosi_bits = 8'h00;
    logic [7:0] slave_word = 8'h00;
    logic       loop_mode = 1'b1;
    logic       slave_bit;

    spi_shift_engine_if #(.WIDTH(8)) bus ();
    spi_shift_engine_if #(.WIDTH(8)) bus4 ();

    spi_shift_engine #(.WIDTH(8), .CLK_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .sclk  (sclk),
        .mosi  (mosi),
        .cs_n  (cs_n),
        .miso  (miso)
    );

    spi_shift_engine #(.WIDTH(8), .CLK_DIV(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave),
        .sclk  (sclk4),
        .mosi  (mosi4),
        .cs_n  (cs_n4),
        .miso  (mosi4)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Cycle counter and rx_valid pulse counter on the main DUT.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rx_valid) valid_count <= valid_count + 1;
    end

    // Capture MOSI at each SCLK rising edge.
    always @(posedge sclk) begin
        rise_count = rise_count + 1;
        mosi_bits  = {mosi_bits[6:0], mosi};
    end

    // Slave model advances its output bit after each SCLK falling edge.
    always @(negedge sclk) begin
        fall_count = fall_count + 1;
    end

    assign slave_bit = (fall_count < 8) ? slave_word[7 - fall_count] : 1'b0;
    assign miso      = loop_mode ? mosi : slave_bit;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Raise tx_start with data, step through the accepting edge and note its cycle.
    task automatic applyStimulus(input logic [7:0] data, input bit hold);
        rise_count   = 0;
        fall_count   = 0;
        mosi_bits    = 8'h00;
        bus.tx_byte  = data;
        bus.tx_start = 1'b1;
        tick();
        e0_cyc = cyc;
        if (!hold) bus.tx_start = 1'b0;
    endtask

    // Wait (bounded) for rx_valid and return cycles since the accepting edge, -1 on timeout.
    task automatic waitValid(output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.rx_valid) begin
                lat = cyc - e0_cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int lat;
        int vc_before;
        int wave_err;
        int lat4;
        logic exp_sclk;

        reset         = 1'b1;
        bus.tx_start  = 1'b0;
        bus.tx_byte   = 8'h00;
        bus4.tx_start = 1'b0;
        bus4.tx_byte  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        checkOutput("reset_tx_ready", bus.tx_ready, 1);
        checkOutput("reset_cs_n", cs_n, 1);
        checkOutput("reset_sclk", sclk, 0);
        checkOutput("reset_mosi", mosi, 0);
        checkOutput("reset_rx_data", bus.rx_data, 8'h00);
        checkOutput("reset_rx_valid", bus.rx_valid, 0);

        $display("[TB] loopback 0xA5");
        loop_mode = 1'b1;
        vc_before = valid_count;
        applyStimulus(8'hA5, 1'b0);
        checkOutput("e0_tx_ready", bus.tx_ready, 0);
        checkOutput("e0_cs_n", cs_n, 0);
        checkOutput("e0_mosi_msb", mosi, 1);
        waitValid(lat);
        checkOutput("a5_latency", lat, 34);
        checkOutput("a5_rx_data", bus.rx_data, 8'hA5);
        checkOutput("a5_rise_count", rise_count, 8);
        checkOutput("a5_done_cs_n", cs_n, 1);
        checkOutput("a5_done_tx_ready", bus.tx_ready, 1);
        tick();
        checkOutput("a5_valid_drop", bus.rx_valid, 0);
        checkOutput("a5_valid_pulses", valid_count - vc_before, 1);

        $display("[TB] slave 0x3C, send 0xC3");
        loop_mode  = 1'b0;
        slave_word = 8'h3C;
        tick();
        applyStimulus(8'hC3, 1'b0);
        waitValid(lat);
        checkOutput("c3_latency", lat, 34);
        checkOutput("c3_mosi_bits", mosi_bits, 8'hC3);
        checkOutput("c3_rx_data", bus.rx_data, 8'h3C);
        loop_mode = 1'b1;
        tick();

        $display("[TB] tx_start held across two transfers");
        vc_before = valid_count;
        applyStimulus(8'h96, 1'b1);
        waitValid(lat);
        checkOutput("held1_latency", lat, 34);
        checkOutput("held1_rx_data", bus.rx_data, 8'h96);
        checkOutput("held1_gap_cs_n", cs_n, 1);
        bus.tx_byte = 8'h69;
        tick();
        checkOutput("held2_tx_ready", bus.tx_ready, 0);
        checkOutput("held2_cs_n", cs_n, 0);
        checkOutput("held2_mosi_msb", mosi, 0);
        e0_cyc       = cyc;
        rise_count   = 0;
        bus.tx_start = 1'b0;
        waitValid(lat);
        checkOutput("held2_latency", lat, 34);
        checkOutput("held2_rx_data", bus.rx_data, 8'h69);
        tick();
        checkOutput("held_valid_pulses", valid_count - vc_before, 2);

        $display("[TB] reset mid-transfer");
        applyStimulus(8'h77, 1'b0);
        repeat (9) tick();
        vc_before = valid_count;
        reset = 1'b1;
        tick();
        checkOutput("abort_cs_n", cs_n, 1);
        checkOutput("abort_sclk", sclk, 0);
        checkOutput("abort_tx_ready", bus.tx_ready, 1);
        checkOutput("abort_rx_data", bus.rx_data, 8'h00);
        checkOutput("abort_rx_valid", bus.rx_valid, 0);
        checkOutput("abort_mosi", mosi, 0);
        reset = 1'b0;
        repeat (40) tick();
        checkOutput("abort_no_valid", valid_count - vc_before, 0);
        applyStimulus(8'h5A, 1'b0);
        waitValid(lat);
        checkOutput("5a_latency", lat, 34);
        checkOutput("5a_rx_data", bus.rx_data, 8'h5A);
        tick();

        $display("[TB] tx_byte changed mid-transfer");
        applyStimulus(8'h0F, 1'b0);
        tick();
        tick();
        bus.tx_byte = 8'hF0;
        waitValid(lat);
        checkOutput("0f_latency", lat, 34);
        checkOutput("0f_mosi_bits", mosi_bits, 8'h0F);
        checkOutput("0f_rx_data", bus.rx_data, 8'h0F);
        tick();

        $display("[TB] CLK_DIV=4 loopback 0xB4");
        bus4.tx_byte  = 8'hB4;
        bus4.tx_start = 1'b1;
        tick();
        bus4.tx_start = 1'b0;
        checkOutput("div4_e0_cs_n", cs_n4, 0);
        wave_err = 0;
        lat4     = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            exp_sclk = (((k / 4) % 2) == 1) && ((k / 4) <= 15);
            if (k < 68 && sclk4 !== exp_sclk) wave_err = wave_err + 1;
            if (bus4.rx_valid) begin
                lat4 = k;
                break;
            end
        end
        checkOutput("div4_sclk_wave_errors", wave_err, 0);
        checkOutput("div4_latency", lat4, 68);
        checkOutput("div4_rx_data", bus4.rx_data, 8'hB4);
        checkOutput("div4_done_cs_n", cs_n4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Bit-level SPI serializer sitting directly downstream of the memory-mapped SPI master port on the picoRV32 bus. It accepts a parallel word plus a one-cycle start strobe from the bus-side register block and drives SCLK/MOSI/CS_N in SPI mode 0 (CPOL=0, CPHA=0), MSB first. It shifts in MISO concurrently, then returns the received word with a one-cycle valid strobe. Its idle/busy flag is the block's `tx_ready` status.

## Interface
- `WIDTH`, 8 — bits per transfer (≥2).
- `CLK_DIV`, 2 — SCLK half-period in `clk` cycles (≥2); SCLK period = 2·CLK_DIV.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `tx_start`  in  1  start strobe; honoured only when `tx_ready`=1.
- `tx_byte`  in  WIDTH  word to transmit; sampled on the accepting edge only.
- `tx_ready`  out  1  1 = idle/accepting, 0 = transfer in progress.
- `rx_data`  out  WIDTH  last received word; holds until next completion.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `sclk`  out  1  SPI clock, idle low.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; synchronous to `clk` at board level.
- `cs_n`  out  1  chip select, active low.

## Operation
- Reset values: `tx_ready`=1, `cs_n`=1, `sclk`=0, `mosi`=0, `rx_data`=0, `rx_valid`=0. Reset mid-transfer aborts it immediately with the same values; no `rx_valid`.
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
- IDLE: on `tx_start`, latch `tx_byte` into the tx shift register, drive `mosi`=bit WIDTH-1, `cs_n`=0, `tx_ready`=0, clear the divider and bit counter, and go to LEAD.
- LEAD: hold for CLK_DIV cycles with `sclk`=0, then go to SHIFT and raise `sclk`.
- SHIFT: on each edge where `sclk` goes 0→1, shift `miso` into the rx shift register LSB. On each 1→0 edge, increment the bit counter. If bits remain, present the next tx bit on `mosi`. After the WIDTH-th falling edge, go to TRAIL.
- TRAIL: hold for CLK_DIV cycles with `sclk`=0 and `cs_n`=0. Then set `cs_n`=1, `rx_data`=rx shift register, `rx_valid`=1, `tx_ready`=1, `mosi`=0, and return to IDLE.
- `tx_start` while busy: ignored, not queued.
- `tx_byte` changes during a transfer have no effect.
- Arithmetic: divider counter is `$clog2(CLK_DIV)` bits and wraps at CLK_DIV-1. Bit counter is `$clog2(WIDTH)+1` bits and never wraps within a transfer.

## Timing
- Acceptance edge E0: `tx_start`=1 and `tx_ready`=1 sampled.
- At E0: `tx_ready`→0, `cs_n`→0, `mosi` = MSB.
- Bit n (0-based): `sclk` rises at E0+CLK_DIV·(2n+1) and falls at E0+CLK_DIV·(2n+2). `miso` is sampled at the rising edge.
- At E0+CLK_DIV·(2·WIDTH+1): `cs_n`→1, `rx_valid`=1, `rx_data` valid, `tx_ready`→1.
- `rx_valid` drops at the following edge.
- Transfer latency: CLK_DIV·(2·WIDTH+1) cycles. Example: WIDTH=8, CLK_DIV=2 gives 34.
- Back-to-back: earliest next acceptance is the first edge after `tx_ready` returns to 1. This guarantees `cs_n` high for at least 1 cycle between words.
- `rx_valid` is a pulse, not a handshake. The consumer must capture it in that cycle.

## Structure
- Shared package `spi_pkg`:
  - FSM state encoding localparams.
  - Mode constants (CPOL/CPHA = 0) reserved for later mode support.
- Sub-module `spi_tick_gen`: divider producing a one-cycle `half_tick` every CLK_DIV cycles, cleared on start.
- The FSM and both shift registers stay in `spi_shift_engine`.

## Test plan
- Loopback (`miso` tied to `mosi`), WIDTH=8, CLK_DIV=2, send 0xA5 → `rx_data`=0xA5. `rx_valid` high exactly at E0+34. Exactly 8 `sclk` rising edges.
- Slave model returns 0x3C while 0xC3 is sent → MOSI bits at successive rising edges read 1,1,0,0,0,0,1,1 and `rx_data`=0x3C.
- `tx_start` held high for the entire transfer, then continuing → second transfer accepted only after `tx_ready`=1. `cs_n` high ≥1 cycle between words. No extra `rx_valid`.
- `reset` asserted at E0+10 → next cycle `cs_n`=1, `sclk`=0, `tx_ready`=1, `rx_data`=0, no `rx_valid`. A subsequent 0x5A loopback completes correctly.
- `tx_byte` changed from 0x0F to 0xF0 at E0+3 → transmitted and received word still 0x0F.
- CLK_DIV=4 → `sclk` high and low phases each exactly 4 cycles. Latency 68 cycles for WIDTH=8.
